// File: rtl/cbus_arbiter.sv
// Two-to-one round-robin arbiter sharing the unified memory bus between ibus and dbus.
// One single-beat transaction in flight at a time, with an optional per-transaction watchdog.
module cbus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [63:0] creq_addr,
  output logic [2:0]  creq_size,
  output logic [7:0]  creq_strobe,
  output logic [63:0] creq_data,
  input  logic        cresp_ok,
  input  logic [63:0] cresp_data,
  output logic        timeout
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_FIRE = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        r_state;
  logic          r_last_d;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_addr;
  logic [63:0]   r_data;
  logic [2:0]    r_size;
  logic [7:0]    r_strobe;

  logic w_idle;
  logic w_busy;
  logic w_grant_i;
  logic w_grant_d;
  logic w_expire;
  logic w_done;

  // Tie goes to whoever was not granted last; r_last_d=0 means ibus went last.
  assign w_idle    = (r_state == IDLE);
  assign w_busy    = !w_idle;
  assign w_grant_i = w_idle && ireq_valid && (!dreq_valid || r_last_d);
  assign w_grant_d = w_idle && dreq_valid && (!ireq_valid || !r_last_d);
  assign w_expire  = (TIMEOUT != 0) && w_busy && !cresp_ok && (r_cnt == CNT_FIRE);
  assign w_done    = w_busy && (cresp_ok || w_expire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= '0;
      r_strobe <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state  <= BUSY_I;
            r_last_d <= 1'b0;
            r_cnt    <= '0;
            r_addr   <= ireq_addr;
            r_data   <= '0;
            r_size   <= 3'b010;
            r_strobe <= '0;
          end else if (w_grant_d) begin
            r_state  <= BUSY_D;
            r_last_d <= 1'b1;
            r_cnt    <= '0;
            r_addr   <= dreq_addr;
            r_data   <= dreq_data;
            r_size   <= dreq_size;
            r_strobe <= dreq_strobe;
          end
        end
        BUSY_I, BUSY_D: begin
          if (w_done) begin
            r_state <= IDLE;
          end else if ((TIMEOUT != 0) && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake pulses follow the current owner; everything is forced low while reset is held.
  always_comb begin
    iresp_addr_ok = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    creq_valid    = 1'b0;
    timeout       = 1'b0;
    if (!rst) begin
      iresp_addr_ok = w_grant_i;
      dresp_addr_ok = w_grant_d;
      iresp_data_ok = (r_state == BUSY_I) && w_done;
      dresp_data_ok = (r_state == BUSY_D) && w_done;
      creq_valid    = w_busy;
      timeout       = w_expire;
      if (iresp_data_ok && cresp_ok) begin
        iresp_data = r_addr[2] ? cresp_data[63:32] : cresp_data[31:0];
      end
      if (dresp_data_ok && cresp_ok) begin
        dresp_data = cresp_data;
      end
    end
  end

  assign creq_is_write = |r_strobe;
  assign creq_addr     = r_addr;
  assign creq_size     = r_size;
  assign creq_strobe   = r_strobe;
  assign creq_data     = r_data;

endmodule
